vm2002_change_dispenser: RTL and testbench
==========================================

# vm2002_change_dispenser

Pays out customer change as a sequence of coins to the coin-return hopper. This is the outbound counterpart of the vending machine's coin-acceptor path. The main vending FSM hands it a change amount in cents at end of transaction. The block selects coins greedily from its own quarter/dime/nickel inventory and drives them one at a time over a valid/ack handshake. It reports completion, any shortfall, and inventory levels, and accepts coin restocking while idle.

## Interface
- `AMOUNT_W`, 8: width of change amount in cents (max 255).
- `CNT_W`, 6: width of each coin inventory counter; saturates at 2^CNT_W-1.
- `INIT_Q`, 20: quarter count loaded at reset.
- `INIT_D`, 20: dime count loaded at reset.
- `INIT_N`, 20: nickel count loaded at reset.
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `change_req`  in  1  start request; sampled only when `busy`=0.
- `change_amt`  in  AMOUNT_W  change owed in cents; sampled with `change_req`.
- `busy`  out  1  high from the cycle after an accepted request through the `done` cycle.
- `coin_out`  out  2  coin being returned, `coins_t` encoding: NICKEL=1, DIME=2, QUARTER=3, NO_COINS=0.
- `coin_valid`  out  1  `coin_out` is valid for the hopper.
- `coin_ack`  in  1  hopper has taken the coin.
- `done`  out  1  one-cycle pulse at the end of the payout.
- `short_change`  out  1  valid with `done`; 1 if any amount was left unpaid.
- `remaining`  out  AMOUNT_W  unpaid cents; valid with `done`, held until the next request.
- `restock`  in  1  add coins to inventory; honoured only when `busy`=0.
- `restock_coin`  in  2  `coins_t` coin type to restock.
- `restock_qty`  in  CNT_W  number of coins to add.
- `q_cnt`, `d_cnt`, `n_cnt`  out  CNT_W each  current inventory counts.
- `exact_change_only`  out  1  combinational; high when `n_cnt`==0.

## Operation
- States: IDLE, SELECT, PRESENT, DONE. One-hot state encoding.
- **IDLE**
  - On `change_req`, load `rem` = `change_amt` and go to SELECT.
  - There is no special case for zero or non-multiple-of-5 amounts.
- **SELECT** (always 1 cycle)
  - Pick the first available coin, in this order:
    - QUARTER if `rem`>=25 and `q_cnt`>0;
    - else DIME if `rem`>=10 and `d_cnt`>0;
    - else NICKEL if `rem`>=5 and `n_cnt`>0.
  - If a coin is picked, latch it and go to PRESENT.
  - If no coin is picked, go to DONE with `short_change` = (`rem`!=0).
- **PRESENT**
  - `coin_valid`=1; `coin_out` = the latched coin, held stable until ack.
  - On `coin_ack`: subtract the coin value (25/10/5) from `rem`, decrement that coin's counter, and go to SELECT.
- **DONE**
  - `done`=1 for one cycle; `remaining`=`rem`; then go to IDLE.
- Selection is strictly greedy with no backtracking. Example: 30 cents with Q=1, D=3, N=0 pays Q and then is short by 5.
- `rem` residue below 5 (e.g. `change_amt`=7) can never be paid. It ends as `short_change`=1 with `remaining` equal to the residue.
- **Restock**
  - In IDLE: `cnt` = min(`cnt`+`restock_qty`, 2^CNT_W-1) for the selected coin.
  - NO_COINS is ignored.
  - Restock while `busy` is ignored entirely.
  - Restock in the same cycle as an accepted `change_req` is applied, and the payout uses the updated counts from SELECT onward.
- `change_req` while `busy` is ignored, not queued.
- `coin_ack` without `coin_valid` is ignored.

## Timing
- **Reset values**
  - IDLE; `busy`=0; `coin_valid`=0; `coin_out`=NO_COINS; `done`=0; `short_change`=0; `remaining`=0.
  - Counters = INIT_Q/INIT_D/INIT_N.
- **Latency**
  - Request at cycle 0 → SELECT cycle 1 → first `coin_valid` cycle 2.
  - With same-cycle ack, each coin takes 2 cycles. `done` asserts at cycle 2+2N for N coins.
  - `change_amt`=0 gives `done` at cycle 2.
- **Handshake**
  - `coin_valid` and `coin_out` are registered.
  - Once `coin_valid` rises it stays high and `coin_out` is unchanged until the cycle `coin_ack` is sampled high.
  - `coin_valid` drops the cycle after ack.
- A new request is accepted in the cycle after `done`.
- **Reset mid-payout**: any coin in flight is abandoned, counts return to their INIT values, and all outputs return to reset values asynchronously.
- **Arithmetic**: `rem` never underflows, because a coin is picked only when its value <= `rem`. Counters never decrement below 0.

## Test plan
- **Reset**: assert `rst_n`=0 mid-PRESENT → `coin_valid`=0, `coin_out`=0, `busy`=0, counts 20/20/20 immediately.
- **Nominal payout**: `change_amt`=65, ack tied high → coins Q, Q, D, N on cycles 2/4/6/8.
  - `done` at cycle 10 with `short_change`=0 and `remaining`=0.
  - Counts end at 18/19/19.
- **Backpressure**: `change_amt`=25, `coin_ack` held low 5 cycles → `coin_out`=QUARTER and `coin_valid` stable for 6 cycles.
  - `done` 2 cycles after ack.
- **Quarter fallback**: INIT_Q=0, `change_amt`=30 → D, D, D; `short_change`=0; `d_cnt`=17.
- **Shortfall and residue**:
  - INIT_D=0, INIT_N=0, `change_amt`=40 → Q only; `short_change`=1, `remaining`=15; `exact_change_only`=1.
  - `change_amt`=7 with full stock → N; `remaining`=2.
- **Restock and request rules**:
  - Restock DIME qty 63 in IDLE → `d_cnt`=63 (saturated).
  - Restock during `busy` → counts unchanged.
  - Second `change_req` while `busy` → ignored; exactly one `done`.

Source files
------------

// File: rtl/vm2002_change_dispenser_if.sv
// Change-dispenser bus: payout request, coin hopper handshake, restock and inventory status.
// The master side is the vending FSM plus hopper; the slave side is the dispenser.
interface vm2002_change_dispenser_if #(
    parameter int AMOUNT_W = 8,
    parameter int CNT_W    = 6
);
    logic                change_req;
    logic [AMOUNT_W-1:0] change_amt;
    logic                busy;
    logic [1:0]          coin_out;
    logic                coin_valid;
    logic                coin_ack;
    logic                done;
    logic                short_change;
    logic [AMOUNT_W-1:0] remaining;
    logic                restock;
    logic [1:0]          restock_coin;
    logic [CNT_W-1:0]    restock_qty;
    logic [CNT_W-1:0]    q_cnt;
    logic [CNT_W-1:0]    d_cnt;
    logic [CNT_W-1:0]    n_cnt;
    logic                exact_change_only;

    modport master (
        output change_req, change_amt, coin_ack, restock, restock_coin, restock_qty,
        input  busy, coin_out, coin_valid, done, short_change, remaining,
               q_cnt, d_cnt, n_cnt, exact_change_only
    );

    modport slave (
        input  change_req, change_amt, coin_ack, restock, restock_coin, restock_qty,
        output busy, coin_out, coin_valid, done, short_change, remaining,
               q_cnt, d_cnt, n_cnt, exact_change_only
    );
endinterface

// File: rtl/vm2002_change_dispenser.sv
// Greedy quarter/dime/nickel change payout over a valid/ack hopper handshake,
// with saturating per-coin inventory counters that can be restocked while idle.
module vm2002_change_dispenser #(
    parameter int AMOUNT_W = 8,
    parameter int CNT_W    = 6,
    parameter int INIT_Q   = 20,
    parameter int INIT_D   = 20,
    parameter int INIT_N   = 20
) (
    input  logic                          clk,
    input  logic                          rst_n,
    vm2002_change_dispenser_if.slave      bus
);
    typedef enum logic [1:0] {
        NO_COINS = 2'd0,
        NICKEL   = 2'd1,
        DIME     = 2'd2,
        QUARTER  = 2'd3
    } coins_t;

    typedef enum logic [3:0] {
        S_IDLE    = 4'b0001,
        S_SELECT  = 4'b0010,
        S_PRESENT = 4'b0100,
        S_DONE    = 4'b1000
    } state_t;

    localparam logic [AMOUNT_W-1:0] VAL_Q = AMOUNT_W'(25);
    localparam logic [AMOUNT_W-1:0] VAL_D = AMOUNT_W'(10);
    localparam logic [AMOUNT_W-1:0] VAL_N = AMOUNT_W'(5);

    state_t              r_state, w_state_next;
    logic [AMOUNT_W-1:0] r_rem;
    coins_t              r_coin_out;
    logic                r_coin_valid;
    logic                r_short;
    logic [AMOUNT_W-1:0] r_remaining;
    coins_t              w_pick;
    logic [AMOUNT_W-1:0] w_coin_val;
    logic                w_accept;
    logic                w_take;
    logic                w_restock_en;
    // Inventory indexed by coin code minus one: [0]=nickel, [1]=dime, [2]=quarter.
    logic [2:0][CNT_W-1:0] w_cnt;

    assign w_accept     = (r_state == S_IDLE) && bus.change_req;
    assign w_take       = (r_state == S_PRESENT) && bus.coin_ack;
    assign w_restock_en = (r_state == S_IDLE) && bus.restock;

    always_comb begin
        w_state_next = r_state;
        w_pick       = NO_COINS;
        case (r_state)
            S_IDLE:    if (bus.change_req) w_state_next = S_SELECT;
            S_SELECT: begin
                if (r_rem >= VAL_Q && w_cnt[2] != '0)      w_pick = QUARTER;
                else if (r_rem >= VAL_D && w_cnt[1] != '0) w_pick = DIME;
                else if (r_rem >= VAL_N && w_cnt[0] != '0) w_pick = NICKEL;
                w_state_next = (w_pick == NO_COINS) ? S_DONE : S_PRESENT;
            end
            S_PRESENT: if (bus.coin_ack) w_state_next = S_SELECT;
            S_DONE:    w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        case (r_coin_out)
            QUARTER: w_coin_val = VAL_Q;
            DIME:    w_coin_val = VAL_D;
            NICKEL:  w_coin_val = VAL_N;
            default: w_coin_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem        <= '0;
            r_coin_out   <= NO_COINS;
            r_coin_valid <= 1'b0;
            r_short      <= 1'b0;
            r_remaining  <= '0;
        end else begin
            if (w_accept) begin
                r_rem       <= bus.change_amt;
                r_short     <= 1'b0;
                r_remaining <= '0;
            end
            if (r_state == S_SELECT) begin
                if (w_pick != NO_COINS) begin
                    r_coin_out   <= w_pick;
                    r_coin_valid <= 1'b1;
                end else begin
                    r_short     <= (r_rem != '0);
                    r_remaining <= r_rem;
                end
            end
            if (w_take) begin
                r_rem        <= r_rem - w_coin_val;
                r_coin_out   <= NO_COINS;
                r_coin_valid <= 1'b0;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cnt
            localparam logic [1:0]       COIN = 2'(gi + 1);
            localparam logic [CNT_W-1:0] INIT = (gi == 0) ? CNT_W'(INIT_N) :
                                                (gi == 1) ? CNT_W'(INIT_D) : CNT_W'(INIT_Q);
            logic [CNT_W-1:0] r_cnt;
            logic [CNT_W:0]   w_sum;

            // One extra bit catches overflow so the count saturates at all-ones.
            assign w_sum    = {1'b0, r_cnt} + {1'b0, bus.restock_qty};
            assign w_cnt[gi] = r_cnt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= INIT;
                end else if (w_restock_en && bus.restock_coin == COIN) begin
                    r_cnt <= w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
                end else if (w_take && r_coin_out == COIN && r_cnt != '0) begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end
    endgenerate

    assign bus.busy              = (r_state != S_IDLE);
    assign bus.done              = (r_state == S_DONE);
    assign bus.coin_out          = r_coin_out;
    assign bus.coin_valid        = r_coin_valid;
    assign bus.short_change      = r_short;
    assign bus.remaining         = r_remaining;
    assign bus.n_cnt             = w_cnt[0];
    assign bus.d_cnt             = w_cnt[1];
    assign bus.q_cnt             = w_cnt[2];
    assign bus.exact_change_only = (w_cnt[0] == '0);
endmodule

// File: tb/tb_vm2002_change_dispenser.sv
// Directed bench for the change dispenser: three instances with different reset inventories
// (0: full stock, 1: no quarters, 2: no dimes/nickels) driven from per-instance stimulus vectors.
module tb_vm2002_change_dispenser;
    localparam logic [1:0] C_NONE = 2'd0, C_N = 2'd1, C_D = 2'd2, C_Q = 2'd3;
    localparam logic [2:0][7:0] IQ = {8'd20, 8'd0,  8'd20};
    localparam logic [2:0][7:0] ID = {8'd0,  8'd20, 8'd20};
    localparam logic [2:0][7:0] IN = {8'd0,  8'd20, 8'd20};

    logic clk;
    logic rst_n;

    logic [2:0]      req_v, ack_v, rs_v;
    logic [2:0][7:0] amt_v;
    logic [2:0][1:0] rs_c;
    logic [2:0][5:0] rs_q;

    logic [2:0]      mon_v, mon_done, mon_busy, mon_short, mon_xo;
    logic [2:0][1:0] mon_coin;
    logic [2:0][7:0] mon_rem;
    logic [2:0][5:0] mon_q, mon_d, mon_n;

    int n_cmp = 0;
    int n_mis = 0;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            vm2002_change_dispenser_if #(.AMOUNT_W(8), .CNT_W(6)) bus ();

            assign bus.change_req   = req_v[gi];
            assign bus.change_amt   = amt_v[gi];
            assign bus.coin_ack     = ack_v[gi];
            assign bus.restock      = rs_v[gi];
            assign bus.restock_coin = rs_c[gi];
            assign bus.restock_qty  = rs_q[gi];

            assign mon_v[gi]     = bus.coin_valid;
            assign mon_coin[gi]  = bus.coin_out;
            assign mon_done[gi]  = bus.done;
            assign mon_busy[gi]  = bus.busy;
            assign mon_short[gi] = bus.short_change;
            assign mon_rem[gi]   = bus.remaining;
            assign mon_q[gi]     = bus.q_cnt;
            assign mon_d[gi]     = bus.d_cnt;
            assign mon_n[gi]     = bus.n_cnt;
            assign mon_xo[gi]    = bus.exact_change_only;

            vm2002_change_dispenser #(
                .AMOUNT_W(8), .CNT_W(6),
                .INIT_Q(int'(IQ[gi])), .INIT_D(int'(ID[gi])), .INIT_N(int'(IN[gi]))
            ) u_dut (
                .clk  (clk),
                .rst_n(rst_n),
                .bus  (bus.slave)
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_counts(input string tag, input int s, input int q, input int d, input int n);
        check($sformatf("%s.q_cnt", tag), 32'(mon_q[s]), q);
        check($sformatf("%s.d_cnt", tag), 32'(mon_d[s]), d);
        check($sformatf("%s.n_cnt", tag), 32'(mon_n[s]), n);
    endtask

    // Payout with ack tied high: coin k (2-bit field k of seq) is presented at cycle 2+2k,
    // done at cycle 2+2n. Optional restock is driven in the same cycle as the request.
    task automatic payout(input string tag, input int s, input logic [7:0] amt, input int n,
                          input logic [15:0] seq, input logic exp_short, input int exp_rem,
                          input logic do_rs, input logic [1:0] rc, input logic [5:0] rq);
        logic       exp_v;
        logic [1:0] exp_coin;
        int         last;
        last = 2 + 2 * n;
        ack_v[s] = 1'b1;
        @(negedge clk);
        req_v[s] = 1'b1; amt_v[s] = amt;
        rs_v[s] = do_rs; rs_c[s] = rc; rs_q[s] = rq;
        for (int c = 1; c <= last + 1; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req_v[s] = 1'b0; rs_v[s] = 1'b0;
            end
            exp_v    = (c >= 2) && (c < last) && (c % 2 == 0);
            exp_coin = exp_v ? seq[2 * ((c - 2) / 2) +: 2] : C_NONE;
            check($sformatf("%s.c%0d.valid", tag, c), 32'(mon_v[s]), 32'(exp_v));
            check($sformatf("%s.c%0d.coin", tag, c), 32'(mon_coin[s]), 32'(exp_coin));
            check($sformatf("%s.c%0d.done", tag, c), 32'(mon_done[s]), 32'(c == last));
            check($sformatf("%s.c%0d.busy", tag, c), 32'(mon_busy[s]), 32'(c <= last));
            if (c == last) begin
                check($sformatf("%s.short", tag), 32'(mon_short[s]), 32'(exp_short));
                check($sformatf("%s.remaining", tag), 32'(mon_rem[s]), exp_rem);
            end
        end
        $display("payout %s: dut%0d amt=%0d coins=%0d short=%0d remaining=%0d",
                 tag, s, amt, n, mon_short[s], mon_rem[s]);
    endtask

    task automatic do_restock(input string tag, input int s, input logic [1:0] rc, input logic [5:0] rq);
        @(negedge clk);
        rs_v[s] = 1'b1; rs_c[s] = rc; rs_q[s] = rq;
        @(negedge clk);
        rs_v[s] = 1'b0;
        $display("restock %s: dut%0d coin=%0d qty=%0d -> q=%0d d=%0d n=%0d",
                 tag, s, rc, rq, mon_q[s], mon_d[s], mon_n[s]);
    endtask

    initial begin
        int ndone;
        req_v = '0; ack_v = '0; rs_v = '0; amt_v = '0; rs_c = '0; rs_q = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        check("rst.busy",  32'(mon_busy[0]),  0);
        check("rst.valid", 32'(mon_v[0]),     0);
        check("rst.coin",  32'(mon_coin[0]),  0);
        check("rst.done",  32'(mon_done[0]),  0);
        check("rst.short", 32'(mon_short[0]), 0);
        check("rst.rem",   32'(mon_rem[0]),   0);
        check("rst.xo0",   32'(mon_xo[0]),    0);
        check("rst.xo2",   32'(mon_xo[2]),    1);
        check_counts("rst", 0, 20, 20, 20);
        check_counts("rst.b", 1, 0, 20, 20);
        $display("reset: dut0 q=%0d d=%0d n=%0d", mon_q[0], mon_d[0], mon_n[0]);

        // Nominal 65 -> Q Q D N
        payout("nom65", 0, 8'd65, 4, {8'd0, C_N, C_D, C_Q, C_Q}, 1'b0, 0, 1'b0, C_NONE, 6'd0);
        check_counts("nom65", 0, 18, 19, 19);

        // Backpressure on a quarter, with restock and a second request while busy
        ack_v[0] = 1'b0;
        ndone = 0;
        @(negedge clk);
        req_v[0] = 1'b1; amt_v[0] = 8'd25;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (c == 1) req_v[0] = 1'b0;
            if (c == 3) begin rs_v[0] = 1'b1; rs_c[0] = C_D; rs_q[0] = 6'd5; end
            if (c == 4) begin rs_v[0] = 1'b0; req_v[0] = 1'b1; amt_v[0] = 8'd10; end
            if (c == 5) req_v[0] = 1'b0;
            if (mon_done[0]) ndone++;
            if (c >= 2 && c <= 7) begin
                check($sformatf("bp.c%0d.valid", c), 32'(mon_v[0]), 1);
                check($sformatf("bp.c%0d.coin", c), 32'(mon_coin[0]), 32'(C_Q));
            end
            if (c == 7) ack_v[0] = 1'b1;
            if (c == 8) begin
                ack_v[0] = 1'b0;
                check("bp.c8.valid", 32'(mon_v[0]), 0);
                check("bp.c8.done",  32'(mon_done[0]), 0);
            end
            if (c == 9) begin
                check("bp.c9.done",  32'(mon_done[0]), 1);
                check("bp.c9.short", 32'(mon_short[0]), 0);
                check("bp.c9.rem",   32'(mon_rem[0]), 0);
            end
            if (c >= 10) check($sformatf("bp.c%0d.busy", c), 32'(mon_busy[0]), 0);
        end
        check("bp.ndone", 32'(ndone), 1);
        check_counts("bp", 0, 17, 19, 19);
        $display("backpressure: dut0 amt=25 done_pulses=%0d", ndone);

        // Restock rules in IDLE
        do_restock("dime63", 0, C_D, 6'd63);
        check_counts("dime63", 0, 17, 63, 19);
        do_restock("none5", 0, C_NONE, 6'd5);
        check_counts("none5", 0, 17, 63, 19);
        do_restock("nickel3", 0, C_N, 6'd3);
        check_counts("nickel3", 0, 17, 63, 22);

        // Residue below a nickel
        payout("res7", 0, 8'd7, 1, {14'd0, C_N}, 1'b1, 2, 1'b0, C_NONE, 6'd0);
        check_counts("res7", 0, 17, 63, 21);

        // Quarter fallback (no quarters)
        payout("fb30", 1, 8'd30, 3, {10'd0, C_D, C_D, C_D}, 1'b0, 0, 1'b0, C_NONE, 6'd0);
        check_counts("fb30", 1, 0, 17, 20);

        // Shortfall (no dimes/nickels)
        payout("short40", 2, 8'd40, 1, {14'd0, C_Q}, 1'b1, 15, 1'b0, C_NONE, 6'd0);
        check("short40.xo", 32'(mon_xo[2]), 1);
        check_counts("short40", 2, 19, 0, 0);

        // Restock in the same cycle as the request feeds the payout
        payout("rsreq5", 2, 8'd5, 1, {14'd0, C_N}, 1'b0, 0, 1'b1, C_N, 6'd1);
        check_counts("rsreq5", 2, 19, 0, 0);

        // Asynchronous reset while a coin is presented
        ack_v[0] = 1'b0;
        @(negedge clk);
        req_v[0] = 1'b1; amt_v[0] = 8'd25;
        @(negedge clk);
        req_v[0] = 1'b0;
        repeat (2) @(negedge clk);
        check("arst.pre.valid", 32'(mon_v[0]), 1);
        rst_n = 1'b0;
        #1;
        check("arst.valid", 32'(mon_v[0]),    0);
        check("arst.coin",  32'(mon_coin[0]), 0);
        check("arst.busy",  32'(mon_busy[0]), 0);
        check_counts("arst", 0, 20, 20, 20);
        $display("async reset: dut0 valid=%0d busy=%0d", mon_v[0], mon_busy[0]);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("arst.post.busy", 32'(mon_busy[0]), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
